// File: rtl/store_unit_pkg.sv
// Shared types and helpers for the store path: queue entry layout, drain FSM
// states and the SB/SH/SW byte-lane formatting.
package store_unit_pkg;

    localparam logic [5:0] ALU_OPERATIONS_SB = 6'h18;
    localparam logic [5:0] ALU_OPERATIONS_SH = 6'h19;
    localparam logic [5:0] ALU_OPERATIONS_SW = 6'h1A;

    typedef struct packed {
        logic [29:0] word_addr;
        logic [31:0] wdata;
        logic [3:0]  byte_en;
    } store_entry_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2
    } drain_state_e;

    function automatic logic is_store_op(input logic [5:0] op);
        return (op == ALU_OPERATIONS_SB) ||
               (op == ALU_OPERATIONS_SH) ||
               (op == ALU_OPERATIONS_SW);
    endfunction

    // Bytes are always aligned; halves need an even address, words a multiple of four.
    function automatic logic is_aligned(input logic [5:0] op, input logic [1:0] a);
        logic ok;
        ok = 1'b0;
        case (op)
            ALU_OPERATIONS_SB: ok = 1'b1;
            ALU_OPERATIONS_SH: ok = ~a[0];
            ALU_OPERATIONS_SW: ok = (a == 2'b00);
            default:           ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic store_entry_t format_store(input logic [5:0]  op,
                                                  input logic [31:0] addr,
                                                  input logic [31:0] data);
        store_entry_t e;
        e.word_addr = addr[31:2];
        e.wdata     = data;
        e.byte_en   = 4'b1111;
        case (op)
            ALU_OPERATIONS_SB: begin
                e.byte_en = 4'b0001 << addr[1:0];
                e.wdata   = {4{data[7:0]}};
            end
            ALU_OPERATIONS_SH: begin
                e.byte_en = addr[1] ? 4'b1100 : 4'b0011;
                e.wdata   = {2{data[15:0]}};
            end
            default: ;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/store_unit_if.sv
// Write-request channel from the store unit to data memory: valid/ready
// request phase followed by a single-cycle completion ack.
interface store_unit_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_byte_en;
    logic        mem_ack;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output mem_req_wdata,
        output mem_req_byte_en,
        input  mem_req_ready,
        input  mem_ack
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  mem_req_wdata,
        input  mem_req_byte_en,
        output mem_req_ready,
        output mem_ack
    );
endinterface

// File: rtl/store_unit_fifo.sv
// In-order store queue. The head stays resident until popped, and every slot
// exports its valid bit and word address so loads can be checked against it.
module store_fifo
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push,
    input  store_entry_t            push_data,
    input  logic                    pop,
    output store_entry_t            head,
    output logic [CW-1:0]           count,
    output logic [DEPTH-1:0]        entry_valid,
    output logic [DEPTH-1:0][29:0]  entry_word_addr
);

    store_entry_t   entries [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop  && (count != '0);

    // Pointers are PW bits wide, so wrap modulo DEPTH falls out of the add.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_pop) begin
                entry_valid[rd_ptr] <= 1'b0;
                rd_ptr              <= rd_ptr + PW'(1);
            end
            if (do_push) begin
                entry_valid[wr_ptr] <= 1'b1;
                wr_ptr              <= wr_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            entries[wr_ptr] <= push_data;
        end
    end

    assign head = entries[rd_ptr];

    always_comb begin
        entry_word_addr = '0;
        for (int i = 0; i < DEPTH; i++) begin
            entry_word_addr[i] = entries[i].word_addr;
        end
    end

endmodule

// File: rtl/store_unit.sv
// Memory-stage store path: formats SB/SH/SW into byte lanes, queues them in
// order and drains them to data memory, flagging loads that hit a pending word.
module store_unit
    import store_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              store_valid,
    output logic              store_ready,
    input  logic [5:0]        alu_operation,
    input  logic [31:0]       store_address,
    input  logic [31:0]       store_data,
    output logic              misaligned,
    input  logic [31:0]       load_address,
    output logic              load_hazard,
    output logic              buffer_empty,
    store_unit_if.master      mem
);

    localparam int CW = $clog2(DEPTH) + 1;

    drain_state_e            state;
    drain_state_e            next_state;
    store_entry_t            new_entry;
    store_entry_t            head;
    logic [CW-1:0]           count;
    logic [CW-1:0]           count_after_pop;
    logic [DEPTH-1:0]        entry_valid;
    logic [DEPTH-1:0][29:0]  entry_word_addr;
    logic                    is_store;
    logic                    aligned;
    logic                    enqueue;
    logic                    pop;
    logic                    unused_load_bits;

    assign unused_load_bits = &{1'b0, load_address[1:0]};

    assign is_store    = is_store_op(alu_operation);
    assign aligned     = is_aligned(alu_operation, store_address[1:0]);
    assign new_entry   = format_store(alu_operation, store_address, store_data);
    assign store_ready = (count != CW'(DEPTH));
    assign enqueue     = store_valid && store_ready && is_store && aligned;
    assign pop         = (state == WAIT_ACK) && mem.mem_ack;

    store_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk             (clk),
        .reset           (reset),
        .push            (enqueue),
        .push_data       (new_entry),
        .pop             (pop),
        .head            (head),
        .count           (count),
        .entry_valid     (entry_valid),
        .entry_word_addr (entry_word_addr)
    );

    // A rejected store is reported for one cycle; it never touches the queue.
    always_ff @(posedge clk) begin
        if (reset) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= store_valid && is_store && !aligned;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Occupancy after the ack, counting a store that lands in the same cycle.
    assign count_after_pop = count + CW'(enqueue) - CW'(1);

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (count != '0) next_state = REQ;
            end
            REQ: begin
                if (mem.mem_req_ready) next_state = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (mem.mem_ack) begin
                    next_state = (count_after_pop != '0) ? REQ : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // The head only moves on pop, so the request fields hold steady through REQ.
    always_comb begin
        mem.mem_req_valid   = 1'b0;
        mem.mem_req_addr    = '0;
        mem.mem_req_wdata   = '0;
        mem.mem_req_byte_en = '0;
        if (state == REQ) begin
            mem.mem_req_valid   = 1'b1;
            mem.mem_req_addr    = {head.word_addr, 2'b00};
            mem.mem_req_wdata   = head.wdata;
            mem.mem_req_byte_en = head.byte_en;
        end
    end

    always_comb begin
        load_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entry_word_addr[i] == load_address[31:2])) begin
                load_hazard = 1'b1;
            end
        end
    end

    assign buffer_empty = (count == '0) && (state == IDLE);

endmodule
